alu_exec_stage: RTL

Execute/writeback stage that sits directly downstream of the 8-bit register file and feeds its write port.
- Consumes two operand values read from the register file plus a decoded opcode and destination address.
- Computes the result and drives the register file's writeEnable_i, regWrite_i, dataWrite_i and ovrflw_i inputs.
- Single-cycle ALU ops complete in 1 cycle; MUL is an iterative 8-cycle shift-add operation with a ready/valid stall.

---
 rtl/alu_exec_stage_pkg.sv | 25 ++
 rtl/alu_exec_stage_mul_iter_8.sv | 58 +++++
 rtl/alu_exec_stage.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/alu_exec_stage_pkg.sv
// Shared definitions for the execute/writeback stage: default widths, opcode
// encodings and FSM state encoding.
package alu_exec_stage_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_ADDR_WIDTH = 4;
  localparam int unsigned OPCODE_WIDTH   = 4;

  localparam logic [OPCODE_WIDTH-1:0] OP_NOP = 4'd0;
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD = 4'd1;
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB = 4'd2;
  localparam logic [OPCODE_WIDTH-1:0] OP_AND = 4'd3;
  localparam logic [OPCODE_WIDTH-1:0] OP_OR  = 4'd4;
  localparam logic [OPCODE_WIDTH-1:0] OP_XOR = 4'd5;
  localparam logic [OPCODE_WIDTH-1:0] OP_SLL = 4'd6;
  localparam logic [OPCODE_WIDTH-1:0] OP_SRL = 4'd7;
  localparam logic [OPCODE_WIDTH-1:0] OP_MOV = 4'd8;
  localparam logic [OPCODE_WIDTH-1:0] OP_MUL = 4'd9;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/alu_exec_stage_mul_iter_8.sv
// Iterative shift-add unsigned multiplier: operands latched on start, one
// partial product accumulated per cycle for WIDTH cycles.
module mul_iter_8
  import alu_exec_stage_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_DATA_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  logic                 running;
  logic [CNT_W-1:0]     cnt;
  logic [2*WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]     mplier;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   accNext;

  // done/product describe the final iteration so the caller can register the
  // result on the same edge that iteration completes.
  always_comb begin
    accNext = acc + (mplier[0] ? mcand : '0);
    done    = running && (cnt == CNT_W'(WIDTH - 1));
    product = accNext;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      running <= 1'b0;
      cnt     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= '0;
      mcand   <= (2*WIDTH)'(a);
      mplier  <= b;
      acc     <= '0;
    end else if (running) begin
      acc    <= accNext;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CNT_W'(1);
      if (cnt == CNT_W'(WIDTH - 1)) begin
        running <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_exec_stage.sv
// Execute/writeback stage feeding the register file write port. Single-cycle
// ALU ops write on the accept edge; MUL stalls while mul_iter_8 iterates.
module alu_exec_stage
  import alu_exec_stage_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic [OPCODE_WIDTH-1:0] opcode_i,
  input  logic [ADDR_WIDTH-1:0]   rd_i,
  input  logic [DATA_WIDTH-1:0]   rs1Data_i,
  input  logic [DATA_WIDTH-1:0]   rs2Data_i,
  output logic                    writeEnable_o,
  output logic [ADDR_WIDTH-1:0]   regWrite_o,
  output logic [DATA_WIDTH-1:0]   dataWrite_o,
  output logic                    ovrflw_o,
  output logic                    busy_o
);

  localparam int unsigned MSB = DATA_WIDTH - 1;

  state_e                  state;
  state_e                  nextState;
  logic                    accept;
  logic                    mulStart;
  logic                    mulDone;
  logic [2*DATA_WIDTH-1:0] mulProduct;
  logic [ADDR_WIDTH-1:0]   mulRd;

  logic [DATA_WIDTH-1:0]   aluResult;
  logic                    aluOvf;
  logic                    aluWrites;
  logic [DATA_WIDTH-1:0]   sum;
  logic [DATA_WIDTH-1:0]   diff;
  logic [2:0]              shamt;

  logic                    weNext;
  logic [ADDR_WIDTH-1:0]   rdNext;
  logic [DATA_WIDTH-1:0]   dataNext;
  logic                    ovfNext;
  logic                    readyNext;
  logic                    busyNext;

  assign accept   = valid_i && ready_o;
  assign mulStart = accept && (state == ST_IDLE) && (opcode_i == OP_MUL);

  mul_iter_8 #(.WIDTH(DATA_WIDTH)) uMul (
    .clk     (clk),
    .rst     (rst),
    .start   (mulStart),
    .a       (rs1Data_i),
    .b       (rs2Data_i),
    .done    (mulDone),
    .product (mulProduct)
  );

  // Single-cycle datapath; aluWrites is low for NOP, MUL and undefined opcodes.
  always_comb begin
    aluResult = '0;
    aluOvf    = 1'b0;
    aluWrites = 1'b1;
    sum       = rs1Data_i + rs2Data_i;
    diff      = rs1Data_i - rs2Data_i;
    shamt     = rs2Data_i[2:0];
    case (opcode_i)
      OP_ADD: begin
        aluResult = sum;
        aluOvf    = (rs1Data_i[MSB] == rs2Data_i[MSB]) && (sum[MSB] != rs1Data_i[MSB]);
      end
      OP_SUB: begin
        aluResult = diff;
        aluOvf    = (rs1Data_i[MSB] != rs2Data_i[MSB]) && (diff[MSB] != rs1Data_i[MSB]);
      end
      OP_AND:  aluResult = rs1Data_i & rs2Data_i;
      OP_OR:   aluResult = rs1Data_i | rs2Data_i;
      OP_XOR:  aluResult = rs1Data_i ^ rs2Data_i;
      OP_SLL:  aluResult = rs1Data_i << shamt;
      OP_SRL:  aluResult = rs1Data_i >> shamt;
      OP_MOV:  aluResult = rs2Data_i;
      default: aluWrites = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      ready_o       <= 1'b1;
      busy_o        <= 1'b0;
      writeEnable_o <= 1'b0;
      regWrite_o    <= '0;
      dataWrite_o   <= '0;
      ovrflw_o      <= 1'b0;
      mulRd         <= '0;
    end else begin
      state         <= nextState;
      ready_o       <= readyNext;
      busy_o        <= busyNext;
      writeEnable_o <= weNext;
      regWrite_o    <= rdNext;
      dataWrite_o   <= dataNext;
      ovrflw_o      <= ovfNext;
      if (mulStart) begin
        mulRd <= rd_i;
      end
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      ST_IDLE: if (mulStart) nextState = ST_MUL;
      ST_MUL:  if (mulDone)  nextState = ST_IDLE;
      default: nextState = ST_IDLE;
    endcase
  end

  // Write payload holds its last value whenever no strobe is issued.
  always_comb begin
    weNext    = 1'b0;
    rdNext    = regWrite_o;
    dataNext  = dataWrite_o;
    ovfNext   = ovrflw_o;
    readyNext = (nextState == ST_IDLE);
    busyNext  = (nextState == ST_MUL);
    case (state)
      ST_IDLE: begin
        if (accept && aluWrites) begin
          weNext   = 1'b1;
          rdNext   = rd_i;
          dataNext = aluResult;
          ovfNext  = aluOvf;
        end
      end
      ST_MUL: begin
        if (mulDone) begin
          weNext   = 1'b1;
          rdNext   = mulRd;
          dataNext = mulProduct[DATA_WIDTH-1:0];
          ovfNext  = |mulProduct[2*DATA_WIDTH-1:DATA_WIDTH];
        end
      end
      default: ;
    endcase
  end

endmodule
